// File: rtl/cellrv32_sdi_host.sv
// cellrv32_sdi_host: byte-oriented SPI mode 0 host engine, MSB first.
// Bytes arrive on a valid/ready port. Received bytes leave as one-cycle pulses.
// sck and mosi come from a clk_i-based phase divider. MISO is resynchronised
// by two flops before it is sampled.
module cellrv32_sdi_host #(
    parameter int HALF_PERIOD = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic       hold_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       busy_o,
    output logic       spi_csn_o,
    output logic       spi_clk_o,
    output logic       spi_dat_o,
    input  logic       spi_dat_i
);

    // Last divider value of a phase; each sck half period spans HALF_PERIOD clk_i cycles.
    localparam logic [7:0] DIV_LAST = 8'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_BYTE_END,
        ST_WAIT,
        ST_TEARDOWN
    } state_t;

    state_t     state;
    logic [7:0] div;
    logic [2:0] bit_cnt;
    logic [7:0] sreg;
    logic       samp;
    logic       miso_meta;
    logic       miso_sync;
    logic       phase_end;
    logic       accept;

    assign phase_end = (div == DIV_LAST);
    // tx_ready_o is registered, so a handshake is judged against the value the source sees.
    assign accept    = tx_valid_i & tx_ready_o;

    // Two-flop synchroniser for the asynchronous MISO line.
    always_ff @(posedge clk_i) begin
        // NOTE: the reset is sampled inside the clocked block, so it is synchronous to clk_i.
        if (rst_i) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let miso_sync take the old miso_meta value, which forms a true two-stage chain.
            miso_meta <= spi_dat_i;
            miso_sync <= miso_meta;
        end
    end

    // Transfer FSM with the divider, shift register and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            div        <= '0;
            bit_cnt    <= '0;
            sreg       <= '0;
            samp       <= 1'b0;
            spi_csn_o  <= 1'b1;
            spi_clk_o  <= 1'b0;
            spi_dat_o  <= 1'b0;
            tx_ready_o <= 1'b0;
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
            busy_o     <= 1'b0;
        end else if (!en_i) begin
            // An abort drops any partial byte and parks the bus idle at once.
            state      <= ST_IDLE;
            div        <= '0;
            bit_cnt    <= '0;
            spi_csn_o  <= 1'b1;
            spi_clk_o  <= 1'b0;
            spi_dat_o  <= 1'b0;
            tx_ready_o <= 1'b0;
            rx_valid_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            // rx_valid_o is a single-cycle pulse. Only the last HIGH phase re-arms it.
            rx_valid_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    spi_csn_o  <= 1'b1;
                    spi_clk_o  <= 1'b0;
                    tx_ready_o <= 1'b1;
                    if (accept) begin
                        sreg       <= tx_data_i;
                        bit_cnt    <= '0;
                        div        <= '0;
                        spi_csn_o  <= 1'b0;
                        spi_dat_o  <= tx_data_i[7];
                        tx_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                        state      <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (phase_end) begin
                        div       <= '0;
                        spi_clk_o <= 1'b1;
                        state     <= ST_HIGH;
                    end else begin
                        div <= div + 8'd1;
                    end
                end

                ST_HIGH: begin
                    // Sample MISO early in the high phase. That leaves the device and the
                    // synchroniser their full latency budget after the preceding falling edge.
                    if (div == '0) begin
                        samp <= miso_sync;
                    end
                    if (phase_end) begin
                        div       <= '0;
                        spi_clk_o <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            rx_data_o  <= {sreg[6:0], samp};
                            rx_valid_o <= 1'b1;
                            // csn follows hold_i now, so it rises in the same cycle as the rx pulse.
                            spi_csn_o  <= ~hold_i;
                            tx_ready_o <= hold_i;
                            state      <= ST_BYTE_END;
                        end else begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            sreg      <= {sreg[6:0], samp};
                            spi_dat_o <= sreg[6];
                            state     <= ST_LOW;
                        end
                    end else begin
                        div <= div + 8'd1;
                    end
                end

                ST_LOW: begin
                    if (phase_end) begin
                        div       <= '0;
                        spi_clk_o <= 1'b1;
                        state     <= ST_HIGH;
                    end else begin
                        div <= div + 8'd1;
                    end
                end

                ST_BYTE_END: begin
                    if (accept) begin
                        // BYTE_END counts as the first cycle of the next low phase.
                        // This keeps burst bytes exactly 16 half periods apart.
                        sreg       <= tx_data_i;
                        bit_cnt    <= '0;
                        spi_dat_o  <= tx_data_i[7];
                        tx_ready_o <= 1'b0;
                        div        <= 8'd1;
                        state      <= ST_LOW;
                    end else if (hold_i && tx_ready_o) begin
                        div   <= '0;
                        state <= ST_WAIT;
                    end else begin
                        // If csn already rose in this cycle, count it toward the high gap.
                        spi_csn_o  <= 1'b1;
                        spi_dat_o  <= 1'b0;
                        tx_ready_o <= 1'b0;
                        div        <= {7'd0, spi_csn_o};
                        state      <= ST_TEARDOWN;
                    end
                end

                ST_WAIT: begin
                    if (accept) begin
                        sreg       <= tx_data_i;
                        bit_cnt    <= '0;
                        spi_dat_o  <= tx_data_i[7];
                        tx_ready_o <= 1'b0;
                        div        <= '0;
                        state      <= ST_LOW;
                    end else if (!hold_i) begin
                        spi_csn_o  <= 1'b1;
                        spi_dat_o  <= 1'b0;
                        tx_ready_o <= 1'b0;
                        div        <= '0;
                        state      <= ST_TEARDOWN;
                    end
                end

                ST_TEARDOWN: begin
                    // csn stays high for a full half period so the device can resynchronise.
                    if (phase_end) begin
                        div        <= '0;
                        tx_ready_o <= 1'b1;
                        busy_o     <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        div <= div + 8'd1;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    div        <= '0;
                    spi_csn_o  <= 1'b1;
                    spi_clk_o  <= 1'b0;
                    tx_ready_o <= 1'b0;
                    busy_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cellrv32_sdi_host.sv
// Directed testbench for cellrv32_sdi_host with HALF_PERIOD=8.
// MISO comes from a MOSI loopback or from a small behavioural mode-0 device.
module tb_cellrv32_sdi_host;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       hold;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       spi_csn;
    logic       spi_clk;
    logic       mosi;
    logic       miso;
    logic       loop_mode;

    int checks   = 0;
    int failures = 0;

    // Behavioural mode-0 device: it shifts out sl_load and captures MOSI on rising sck.
    logic [7:0] sl_load = 8'h3C;
    logic [7:0] sl_tx   = 8'h00;
    logic [7:0] sl_rx   = 8'h00;
    logic       sl_miso = 1'b0;
    logic       sl_sck_q = 1'b0;

    always #5 clk = ~clk;

    assign miso = loop_mode ? mosi : sl_miso;

    // The device model updates its own state from the host outputs on each clock.
    always @(posedge clk) begin
        sl_sck_q <= spi_clk;
        if (spi_csn) begin
            sl_tx   <= sl_load;
            sl_miso <= sl_load[7];
        end else if (spi_clk && !sl_sck_q) begin
            sl_rx <= {sl_rx[6:0], mosi};
        end else if (!spi_clk && sl_sck_q) begin
            sl_tx   <= {sl_tx[6:0], 1'b0};
            sl_miso <= sl_tx[6];
        end
    end

    cellrv32_sdi_host #(.HALF_PERIOD(H)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .hold_i     (hold),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .busy_o     (busy),
        .spi_csn_o  (spi_csn),
        .spi_clk_o  (spi_clk),
        .spi_dat_o  (mosi),
        .spi_dat_i  (miso)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!tx_ready && n < 200) begin
            tick();
            n++;
        end
        if (!tx_ready) begin
            checks++;
            failures++;
            $display("FAIL wait_ready timeout got=%0b exp=1", tx_ready);
        end
    endtask

    // Sends one byte with hold low. It reports every rx pulse seen within a bounded window.
    task automatic send_byte(input logic [7:0] b, output logic [7:0] rb, output int rcnt, output int rcyc);
        wait_ready();
        tx_data  = b;
        tx_valid = 1'b1;
        rcnt = 0;
        rcyc = -1;
        rb   = 8'h00;
        for (int k = 1; k <= 1 + 17 * H + 4; k++) begin
            tick();
            if (k == 1) tx_valid = 1'b0;
            if (rx_valid) begin
                rcnt++;
                rcyc = k;
                rb   = rx_data;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (spi_csn !== 1'b1)  begin failures++; $display("FAIL reset_csn got=%0b exp=1", spi_csn); end
        checks++; if (spi_clk !== 1'b0)  begin failures++; $display("FAIL reset_sck got=%0b exp=0", spi_clk); end
        checks++; if (mosi !== 1'b0)     begin failures++; $display("FAIL reset_mosi got=%0b exp=0", mosi); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rxv got=%0b exp=0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rxd got=%0h exp=00", rx_data); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        rst = 1'b0;
        tick();
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%0b exp=1", tx_ready); end
    endtask

    task automatic test_loopback_single();
        int first_low, last_low, first_sck, rises, rx_cnt, rx_cyc, ready_cyc;
        logic sck_prev, csn_at_rx;
        logic [7:0] rx_b;
        loop_mode = 1'b1;
        hold = 1'b0;
        wait_ready();
        first_low = -1; last_low = -1; first_sck = -1; rises = 0;
        rx_cnt = 0; rx_cyc = -1; ready_cyc = -1; sck_prev = 1'b0; csn_at_rx = 1'b0; rx_b = 8'h00;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (k == 1) tx_valid = 1'b0;
            if (!spi_csn) begin
                if (first_low < 0) first_low = k;
                last_low = k;
            end
            if (spi_clk && !sck_prev) begin
                rises++;
                if (first_sck < 0) first_sck = k;
            end
            sck_prev = spi_clk;
            if (rx_valid) begin
                rx_cnt++;
                rx_cyc = k;
                rx_b = rx_data;
                csn_at_rx = spi_csn;
            end
            if (tx_ready && ready_cyc < 0) ready_cyc = k;
        end
        checks++; if (first_low !== 1)          begin failures++; $display("FAIL single_csn_fall got=%0d exp=1", first_low); end
        checks++; if (last_low !== 16 * H)      begin failures++; $display("FAIL single_csn_last_low got=%0d exp=%0d", last_low, 16 * H); end
        checks++; if (first_sck !== 1 + H)      begin failures++; $display("FAIL single_first_sck got=%0d exp=%0d", first_sck, 1 + H); end
        checks++; if (rises !== 8)              begin failures++; $display("FAIL single_sck_rises got=%0d exp=8", rises); end
        checks++; if (rx_cnt !== 1)             begin failures++; $display("FAIL single_rx_count got=%0d exp=1", rx_cnt); end
        checks++; if (rx_cyc !== 1 + 16 * H)    begin failures++; $display("FAIL single_rx_cycle got=%0d exp=%0d", rx_cyc, 1 + 16 * H); end
        checks++; if (rx_b !== 8'hA5)           begin failures++; $display("FAIL single_rx_data got=%0h exp=a5", rx_b); end
        checks++; if (csn_at_rx !== 1'b1)       begin failures++; $display("FAIL single_csn_at_rx got=%0b exp=1", csn_at_rx); end
        checks++; if (ready_cyc !== 1 + 17 * H) begin failures++; $display("FAIL single_ready_back got=%0d exp=%0d", ready_cyc, 1 + 17 * H); end
    endtask

    task automatic test_sdi_device();
        logic [7:0] rb;
        int rcnt, rcyc;
        loop_mode = 1'b0;
        hold = 1'b0;
        sl_load = 8'h3C;
        send_byte(8'h96, rb, rcnt, rcyc);
        checks++; if (rb !== 8'h3C)    begin failures++; $display("FAIL sdi_host_rx got=%0h exp=3c", rb); end
        checks++; if (sl_rx !== 8'h96) begin failures++; $display("FAIL sdi_device_rx got=%0h exp=96", sl_rx); end
        checks++; if (rcnt !== 1)      begin failures++; $display("FAIL sdi_rx_count got=%0d exp=1", rcnt); end
        loop_mode = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat [3];
        logic [7:0] got [3];
        int cyc [3];
        int idx, n_rx, csn_high;
        logic acc, csn_after;
        pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h03;
        got[0] = 8'h00; got[1] = 8'h00; got[2] = 8'h00;
        cyc[0] = -1; cyc[1] = -1; cyc[2] = -1;
        idx = 0; n_rx = 0; csn_high = 0; csn_after = 1'b0;
        loop_mode = 1'b1;
        hold = 1'b1;
        wait_ready();
        tx_data  = pat[0];
        tx_valid = 1'b1;
        for (int k = 1; k <= 48 * H + H + 20; k++) begin
            acc = tx_valid && tx_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    tx_data = pat[idx];
                end else begin
                    tx_valid = 1'b0;
                    hold = 1'b0;
                end
            end
            if (k < 1 + 48 * H && spi_csn) csn_high++;
            if (rx_valid) begin
                if (n_rx < 3) begin
                    got[n_rx] = rx_data;
                    cyc[n_rx] = k;
                end
                n_rx++;
                if (n_rx == 3) csn_after = spi_csn;
            end
        end
        tx_valid = 1'b0;
        hold = 1'b0;
        checks++; if (n_rx !== 3)          begin failures++; $display("FAIL burst_rx_count got=%0d exp=3", n_rx); end
        checks++; if (csn_high !== 0)      begin failures++; $display("FAIL burst_csn_high_cycles got=%0d exp=0", csn_high); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (got[i] !== pat[i]) begin failures++; $display("FAIL burst_rx_data[%0d] got=%0h exp=%0h", i, got[i], pat[i]); end
            checks++; if (cyc[i] !== 1 + 16 * H * (i + 1)) begin failures++; $display("FAIL burst_rx_cycle[%0d] got=%0d exp=%0d", i, cyc[i], 1 + 16 * H * (i + 1)); end
        end
        checks++; if (csn_after !== 1'b1)  begin failures++; $display("FAIL burst_csn_end got=%0b exp=1", csn_after); end
    endtask

    task automatic test_wait_teardown();
        logic [7:0] rb;
        int high_cnt, n;
        rb = 8'h00;
        loop_mode = 1'b1;
        hold = 1'b1;
        wait_ready();
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        for (int k = 1; k <= 11 + 16 * H; k++) begin
            tick();
            if (k == 1) tx_valid = 1'b0;
            if (rx_valid) rb = rx_data;
        end
        checks++; if (rb !== 8'h5A)      begin failures++; $display("FAIL wait_rx_data got=%0h exp=5a", rb); end
        checks++; if (spi_csn !== 1'b0)  begin failures++; $display("FAIL wait_csn got=%0b exp=0", spi_csn); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL wait_ready_flag got=%0b exp=1", tx_ready); end
        checks++; if (busy !== 1'b1)     begin failures++; $display("FAIL wait_busy got=%0b exp=1", busy); end
        checks++; if (spi_clk !== 1'b0)  begin failures++; $display("FAIL wait_sck got=%0b exp=0", spi_clk); end
        hold = 1'b0;
        tick();
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL teardown_ready got=%0b exp=0", tx_ready); end
        checks++; if (busy !== 1'b1)     begin failures++; $display("FAIL teardown_busy got=%0b exp=1", busy); end
        high_cnt = 0;
        n = 0;
        while (!tx_ready && n < 50) begin
            if (spi_csn) high_cnt++;
            tick();
            n++;
        end
        checks++; if (high_cnt !== H)    begin failures++; $display("FAIL teardown_csn_high got=%0d exp=%0d", high_cnt, H); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL teardown_idle_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_abort();
        int rises, rx_seen, rcnt, rcyc;
        logic sck_prev;
        logic [7:0] rb;
        loop_mode = 1'b1;
        hold = 1'b0;
        wait_ready();
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        rises = 0;
        sck_prev = 1'b0;
        for (int k = 1; k <= 300 && rises < 5; k++) begin
            tick();
            if (k == 1) tx_valid = 1'b0;
            if (spi_clk && !sck_prev) rises++;
            sck_prev = spi_clk;
        end
        checks++; if (rises !== 5) begin failures++; $display("FAIL abort_reach_bit4 got=%0d exp=5", rises); end
        en = 1'b0;
        tick();
        checks++; if (spi_csn !== 1'b1)  begin failures++; $display("FAIL abort_csn got=%0b exp=1", spi_csn); end
        checks++; if (spi_clk !== 1'b0)  begin failures++; $display("FAIL abort_sck got=%0b exp=0", spi_clk); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL abort_rxv got=%0b exp=0", rx_valid); end
        en = 1'b1;
        rx_seen = 0;
        for (int k = 0; k < 20 * H; k++) begin
            tick();
            if (rx_valid) rx_seen++;
        end
        checks++; if (rx_seen !== 0) begin failures++; $display("FAIL abort_no_rx got=%0d exp=0", rx_seen); end
        send_byte(8'h3C, rb, rcnt, rcyc);
        checks++; if (rb !== 8'h3C)         begin failures++; $display("FAIL abort_next_rx got=%0h exp=3c", rb); end
        checks++; if (rcyc !== 1 + 16 * H)  begin failures++; $display("FAIL abort_next_cycle got=%0d exp=%0d", rcyc, 1 + 16 * H); end
    endtask

    task automatic test_rst_mid();
        int rx_seen, ready_busy, rx_cnt, n;
        logic [7:0] rb;
        loop_mode = 1'b1;
        hold = 1'b0;
        wait_ready();
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        for (int k = 1; k <= 5 * H; k++) begin
            tick();
            if (k == 1) tx_valid = 1'b0;
        end
        rst = 1'b1;
        tick();
        checks++; if (spi_csn !== 1'b1)  begin failures++; $display("FAIL rstmid_csn got=%0b exp=1", spi_csn); end
        checks++; if (spi_clk !== 1'b0)  begin failures++; $display("FAIL rstmid_sck got=%0b exp=0", spi_clk); end
        checks++; if (mosi !== 1'b0)     begin failures++; $display("FAIL rstmid_mosi got=%0b exp=0", mosi); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%0b exp=0", tx_ready); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rstmid_rxd got=%0h exp=00", rx_data); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        rst = 1'b0;
        rx_seen = 0;
        for (int k = 0; k < 18 * H; k++) begin
            tick();
            if (rx_valid) rx_seen++;
        end
        checks++; if (rx_seen !== 0) begin failures++; $display("FAIL rstmid_no_rx got=%0d exp=0", rx_seen); end

        // A second byte offered while busy must wait until the engine returns to IDLE.
        wait_ready();
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'h7E;
        ready_busy = 0;
        rx_cnt = 0;
        rb = 8'h00;
        n = 0;
        while (!tx_ready && n < 20 * H) begin
            if (busy && tx_ready) ready_busy++;
            if (rx_valid) begin
                rx_cnt++;
                rb = rx_data;
            end
            tick();
            n++;
        end
        tx_valid = 1'b0;
        checks++; if (ready_busy !== 0)  begin failures++; $display("FAIL busy_ready_cycles got=%0d exp=0", ready_busy); end
        checks++; if (rx_cnt !== 1)      begin failures++; $display("FAIL busy_rx_count got=%0d exp=1", rx_cnt); end
        checks++; if (rb !== 8'h81)      begin failures++; $display("FAIL busy_rx_data got=%0h exp=81", rb); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL busy_ready_back got=%0b exp=1", tx_ready); end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        hold      = 1'b0;
        loop_mode = 1'b1;

        test_reset();
        test_loopback_single();
        test_sdi_device();
        test_back_to_back();
        test_wait_teardown();
        test_abort();
        test_rst_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
